// File: rtl/fx_pkg.sv
// Shared types and sizing for the tap-effects datapath.
// Pure declarations: no latency, no flow control.
package fx_pkg;
    localparam int DW_DEF       = 10;
    localparam int ADDR_W_DEF   = 13;
    localparam int NUM_TAPS_DEF = 4;
    localparam int CAL_LOG2_DEF = 12;

    typedef enum logic [2:0] {
        ST_CAL,
        ST_IDLE,
        ST_TAP,
        ST_WRITE,
        ST_SHAPE,
        ST_OUT
    } fx_state_t;

    // Dry sample plus NUM_TAPS delayed words, each DW+1 bits signed, without overflow.
    function automatic int acc_w(input int dw, input int num_taps);
        return dw + 1 + $clog2(num_taps + 1);
    endfunction
endpackage

// File: rtl/fx_delay_ram.sv
// Simple dual-port delay memory, one write and one registered read per cycle.
// Read data 1 cycle after rd_en; no backpressure, contents not reset.
module fx_delay_ram #(
    parameter int ADDR_W = 13,
    parameter int WORD_W = 11
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);
    logic [WORD_W-1:0] mem [0:(1 << ADDR_W) - 1];
    logic [WORD_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/fx_tap_engine.sv
// Bias-calibrated multi-tap delay effect with overdrive and sign-magnitude output.
// Latency NUM_TAPS+5 cycles; no backpressure, samples arriving while busy are dropped and flagged.
module fx_tap_engine
    import fx_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_TAPS = NUM_TAPS_DEF,
    parameter int CAL_LOG2 = CAL_LOG2_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            sample_valid,
    input  logic [DW-1:0]                   sample_in,
    input  logic                            recal,
    input  logic [NUM_TAPS-1:0]             tap_en,
    input  logic [NUM_TAPS-1:0][ADDR_W-1:0] tap_delay,
    input  logic                            drive_en,
    input  logic [2:0]                      drive_shift,
    output logic                            out_valid,
    output logic                            out_sign,
    output logic [DW-1:0]                   out_mag,
    output logic                            calibrating,
    output logic                            overrun,
    output logic [7:0]                      level
);
    localparam int ACC_W  = acc_w(DW, NUM_TAPS);
    localparam int WORD_W = DW + 1;
    localparam int MAG_W  = ACC_W + 7;
    localparam int TI_W   = $clog2(NUM_TAPS + 1);
    localparam int SEL_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int CNT_W  = CAL_LOG2 + 1;
    localparam int SUM_W  = DW + CAL_LOG2;
    localparam logic [TI_W-1:0]  LAST_TAP  = TI_W'(NUM_TAPS);
    localparam logic [CNT_W-1:0] CAL_COUNT = CNT_W'(2 ** CAL_LOG2);
    localparam logic [MAG_W-1:0] MAG_MAX   = MAG_W'(2 ** DW - 1);

    fx_state_t                 state_q, state_d;
    logic [SUM_W-1:0]          sum_q, sum_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DW-1:0]             offset_q, offset_d;
    logic [ADDR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]         fill_q, fill_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [WORD_W-1:0]         centred_q, centred_d;
    logic [TI_W-1:0]           tap_i_q, tap_i_d;
    logic                      hit_q, hit_d;
    logic                      sign_q, sign_d;
    logic [DW-1:0]             mag_q, mag_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_sign_q, out_sign_d;
    logic [DW-1:0]             out_mag_q, out_mag_d;
    logic                      overrun_q, overrun_d;

    logic                      rd_en, wr_en;
    logic [ADDR_W-1:0]         rd_addr;
    logic [WORD_W-1:0]         rd_data;
    logic [SEL_W-1:0]          tap_sel;
    logic [ADDR_W-1:0]         eff_delay;
    logic                      tap_hit;
    logic [MAG_W-1:0]          acc_ext, abs_mag, shifted;
    logic [DW-1:0]             shaped_mag;

    // A zero delay would read the slot about to be overwritten, so it is clamped to one.
    always_comb begin
        tap_sel   = tap_i_q[SEL_W-1:0];
        eff_delay = (tap_delay[tap_sel] == '0) ? ADDR_W'(1) : tap_delay[tap_sel];
        tap_hit   = tap_en[tap_sel] && (eff_delay <= fill_q);
        rd_addr   = wr_ptr_q - eff_delay;
    end

    // Magnitude is formed in a wider field so negation and gain cannot wrap before clamping.
    always_comb begin
        acc_ext    = MAG_W'(acc_q);
        abs_mag    = acc_q[ACC_W-1] ? (~acc_ext + 1'b1) : acc_ext;
        shifted    = drive_en ? (abs_mag << drive_shift) : abs_mag;
        shaped_mag = (shifted > MAG_MAX) ? DW'(MAG_MAX) : shifted[DW-1:0];
    end

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        offset_d    = offset_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        acc_d       = acc_q;
        centred_d   = centred_q;
        tap_i_d     = tap_i_q;
        hit_d       = hit_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        out_valid_d = 1'b0;
        out_sign_d  = out_sign_q;
        out_mag_d   = out_mag_q;
        overrun_d   = overrun_q;
        rd_en       = 1'b0;
        wr_en       = 1'b0;

        case (state_q)
            ST_CAL: begin
                if (sample_valid) begin
                    sum_d = sum_q + SUM_W'(sample_in);
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CAL_COUNT) begin
                        offset_d = sum_d[CAL_LOG2 +: DW];
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (sample_valid) begin
                    centred_d = {1'b0, sample_in} - {1'b0, offset_q};
                    acc_d     = ACC_W'($signed(centred_d));
                    tap_i_d   = '0;
                    state_d   = ST_TAP;
                end
            end
            ST_TAP: begin
                // Address for tap i goes out in cycle i; its word returns in cycle i+1.
                if (tap_i_q != LAST_TAP) begin
                    rd_en = 1'b1;
                    hit_d = tap_hit;
                end else begin
                    hit_d = 1'b0;
                end
                if ((tap_i_q != '0) && hit_q) begin
                    acc_d = acc_q + ACC_W'($signed(rd_data));
                end
                tap_i_d = tap_i_q + 1'b1;
                if (tap_i_q == LAST_TAP) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (fill_q != '1) begin
                    fill_d = fill_q + 1'b1;
                end
                state_d = ST_SHAPE;
            end
            ST_SHAPE: begin
                sign_d  = acc_q[ACC_W-1];
                mag_d   = shaped_mag;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                out_valid_d = 1'b1;
                out_sign_d  = sign_q;
                out_mag_d   = mag_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_CAL;
        endcase

        if (sample_valid && (state_q inside {ST_TAP, ST_WRITE, ST_SHAPE, ST_OUT})) begin
            overrun_d = 1'b1;
        end

        if (recal) begin
            sum_d     = '0;
            cnt_d     = '0;
            fill_d    = '0;
            overrun_d = 1'b0;
            state_d   = ST_CAL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_CAL;
            sum_q       <= '0;
            cnt_q       <= '0;
            offset_q    <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            acc_q       <= '0;
            centred_q   <= '0;
            tap_i_q     <= '0;
            hit_q       <= 1'b0;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_mag_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            offset_q    <= offset_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            acc_q       <= acc_d;
            centred_q   <= centred_d;
            tap_i_q     <= tap_i_d;
            hit_q       <= hit_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_mag_q   <= out_mag_d;
            overrun_q   <= overrun_d;
        end
    end

    fx_delay_ram #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (centred_q),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign out_valid   = out_valid_q;
    assign out_sign    = out_sign_q;
    assign out_mag     = out_mag_q;
    assign calibrating = (state_q == ST_CAL);
    assign overrun     = overrun_q;
    assign level       = out_mag_q[DW-1 -: 8];
endmodule

// File: tb/tb_fx_tap_engine.sv
// Directed bench for fx_tap_engine: a default-depth instance plus a 16-deep instance for pointer wrap.
module tb_fx_tap_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             sample_valid, recal, drive_en;
    logic [9:0]       sample_in;
    logic [3:0]       tap_en;
    logic [3:0][12:0] tap_delay;
    logic [2:0]       drive_shift;
    logic             out_valid, out_sign, calibrating, overrun;
    logic [9:0]       out_mag;
    logic [7:0]       level;

    logic             w_sample_valid, w_recal, w_drive_en;
    logic [9:0]       w_sample_in;
    logic [3:0]       w_tap_en;
    logic [3:0][3:0]  w_tap_delay;
    logic [2:0]       w_drive_shift;
    logic             w_out_valid, w_out_sign, w_calibrating, w_overrun;
    logic [9:0]       w_out_mag;
    logic [7:0]       w_level;

    int checks   = 0;
    int failures = 0;
    int ov_cnt   = 0;
    int base;

    fx_tap_engine #(.DW(10), .ADDR_W(13), .NUM_TAPS(4), .CAL_LOG2(4)) u_dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
        .recal(recal), .tap_en(tap_en), .tap_delay(tap_delay), .drive_en(drive_en),
        .drive_shift(drive_shift), .out_valid(out_valid), .out_sign(out_sign),
        .out_mag(out_mag), .calibrating(calibrating), .overrun(overrun), .level(level)
    );

    fx_tap_engine #(.DW(10), .ADDR_W(4), .NUM_TAPS(4), .CAL_LOG2(4)) u_wrap (
        .clk(clk), .reset(reset), .sample_valid(w_sample_valid), .sample_in(w_sample_in),
        .recal(w_recal), .tap_en(w_tap_en), .tap_delay(w_tap_delay), .drive_en(w_drive_en),
        .drive_shift(w_drive_shift), .out_valid(w_out_valid), .out_sign(w_out_sign),
        .out_mag(w_out_mag), .calibrating(w_calibrating), .overrun(w_overrun), .level(w_level)
    );

    always @(negedge clk) if (out_valid === 1'b1) ov_cnt <= ov_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input bit wrap, input logic [9:0] x);
        if (wrap) begin
            w_sample_in = x; w_sample_valid = 1'b1;
        end else begin
            sample_in = x; sample_valid = 1'b1;
        end
        @(negedge clk);
        w_sample_valid = 1'b0;
        sample_valid   = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input logic [9:0] x, input string tag, input logic exp_sign,
                        input logic [9:0] exp_mag);
        int lat;
        lat = 0;
        sample_in = x; sample_valid = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) sample_valid = 1'b0;
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'd9);
        check({tag, "_sign"}, 32'(out_sign), 32'(exp_sign));
        check({tag, "_mag"}, 32'(out_mag), 32'(exp_mag));
        check({tag, "_level"}, 32'(level), 32'(exp_mag[9:2]));
        @(negedge clk);
    endtask

    task automatic w_send(input logic [9:0] x, input string tag, input logic [9:0] exp_mag);
        int lat;
        lat = 0;
        w_sample_in = x; w_sample_valid = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) w_sample_valid = 1'b0;
            if (w_out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'd9);
        check({tag, "_mag"}, 32'(w_out_mag), 32'(exp_mag));
        check({tag, "_sign"}, 32'(w_out_sign), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [9:0] ramp;
        reset = 1'b1;
        sample_valid = 1'b0; sample_in = '0; recal = 1'b0; tap_en = '0; tap_delay = '0;
        drive_en = 1'b0; drive_shift = '0;
        w_sample_valid = 1'b0; w_sample_in = '0; w_recal = 1'b0; w_tap_en = '0; w_tap_delay = '0;
        w_drive_en = 1'b0; w_drive_shift = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_calibrating", 32'(calibrating), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sign", 32'(out_sign), 32'd0);
        check("rst_out_mag", 32'(out_mag), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_level", 32'(level), 32'd0);

        for (int i = 0; i < 15; i++) pulse(1'b0, 10'h200);
        check("cal_busy_after_15", 32'(calibrating), 32'd1);
        pulse(1'b0, 10'h200);
        check("cal_done_after_16", 32'(calibrating), 32'd0);
        check("cal_no_out", 32'(ov_cnt), 32'd0);

        send(10'h200, "centre_zero", 1'b0, 10'h000);
        send(10'h100, "dry_neg", 1'b1, 10'h100);

        // Second strobe lands two cycles into the first sample's tap sequence.
        check("ovr_pre", 32'(overrun), 32'd0);
        base = ov_cnt;
        sample_in = 10'h200; sample_valid = 1'b1;
        @(negedge clk); sample_valid = 1'b0;
        @(negedge clk); sample_valid = 1'b1;
        @(negedge clk); sample_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_single_out", 32'(ov_cnt - base), 32'd1);

        base = ov_cnt;
        recal = 1'b1; sample_valid = 1'b1; sample_in = 10'h3FF;
        @(negedge clk);
        recal = 1'b0; sample_valid = 1'b0;
        check("recal_calibrating", 32'(calibrating), 32'd1);
        check("recal_ovr_clear", 32'(overrun), 32'd0);
        recal = 1'b1; sample_valid = 1'b1; sample_in = 10'h3FF;
        @(negedge clk);
        recal = 1'b0; sample_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) pulse(1'b0, 10'h200);
        check("recal_done", 32'(calibrating), 32'd0);
        check("recal_no_out", 32'(ov_cnt - base), 32'd0);

        // Fill restarts at zero, so stale RAM words behind the tap must not leak in.
        tap_en = 4'b0001; tap_delay[0] = 13'd3;
        send(10'h250, "tap_s1", 1'b0, 10'h050);
        send(10'h200, "tap_s2", 1'b0, 10'h000);
        send(10'h200, "tap_s3", 1'b0, 10'h000);
        send(10'h200, "tap_s4", 1'b0, 10'h050);

        tap_en = 4'b1111;
        for (int t = 0; t < 4; t++) tap_delay[t] = 13'd1;
        send(10'h3FF, "sat_first", 1'b0, 10'h1FF);
        for (int i = 0; i < 3; i++) send(10'h3FF, "sat_steady", 1'b0, 10'h3FF);
        send(10'h000, "sat_mixed", 1'b0, 10'h3FF);
        send(10'h000, "sat_negative", 1'b1, 10'h3FF);

        tap_en = 4'b0000; drive_en = 1'b1; drive_shift = 3'd3;
        send(10'h240, "drive_x8", 1'b0, 10'h200);
        send(10'h280, "drive_sat", 1'b0, 10'h3FF);
        send(10'h1F0, "drive_neg", 1'b1, 10'h080);

        drive_en = 1'b0; tap_en = 4'b0001; tap_delay[0] = 13'd0;
        send(10'h210, "delay0_as_1", 1'b0, 10'h000);

        w_tap_en = 4'b0001; w_tap_delay[0] = 4'd15;
        for (int i = 0; i < 16; i++) pulse(1'b1, 10'h200);
        check("wrap_cal_done", 32'(w_calibrating), 32'd0);
        for (int n = 0; n < 40; n++) begin
            ramp = 10'h200 + 10'(n);
            w_send(ramp, $sformatf("wrap%0d", n), (n < 15) ? 10'(n) : 10'(2 * n - 15));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
